// File: rtl/acc_control_fsm.sv
// acc_control_fsm: multi-cycle fetch/decode/execute sequencer for the
// accumulator processor. It drives the datapath control strobes, handshakes
// with a variable-latency memory, flags undefined opcodes and memory
// timeouts, and counts retired instructions.
module acc_control_fsm #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       opcode_i,
    input  logic             acc_zero_i,
    input  logic             mem_ready_i,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             iord_o,
    output logic             acc_write_o,
    output logic [1:0]       acc_src_o,
    output logic [2:0]       alu_op_o,
    output logic             halted_o,
    output logic             illegal_op_o,
    output logic             bus_error_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_EXEC_ALU = 3'd2;
    localparam logic [2:0] S_MEM_RD   = 3'd3;
    localparam logic [2:0] S_MEM_WR   = 3'd4;
    localparam logic [2:0] S_BRANCH   = 3'd5;
    localparam logic [2:0] S_HALT     = 3'd6;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_ADD   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_AND   = 5'h03;
    localparam logic [4:0] OP_OR    = 5'h04;
    localparam logic [4:0] OP_LOAD  = 5'h05;
    localparam logic [4:0] OP_STORE = 5'h06;
    localparam logic [4:0] OP_LOADI = 5'h07;
    localparam logic [4:0] OP_BEQZ  = 5'h08;
    localparam logic [4:0] OP_JUMP  = 5'h09;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    // The counter holds the number of not-ready cycles already spent, so the
    // WAIT_LIMIT-th consecutive not-ready cycle is the one seen at LIMIT-1.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    logic [2:0]       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             mem_state;
    logic             timeout;
    logic             retire;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                       (state_q == S_MEM_WR);
    // A ready in the limit cycle still completes the access.
    assign timeout   = mem_state && !mem_ready_i && (wait_q == WAIT_LAST);

    // Next-state, sticky-flag and retirement decisions.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_NOP: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOADI: state_d = S_EXEC_ALU;
                    OP_LOAD:                                 state_d = S_MEM_RD;
                    OP_STORE:                                state_d = S_MEM_WR;
                    OP_BEQZ, OP_JUMP:                        state_d = S_BRANCH;
                    OP_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        // Undefined opcodes are flagged and retired as NOPs.
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                        retire    = 1'b1;
                    end
                endcase
            end
            S_EXEC_ALU, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Wait counter advances only while a memory access is stalled.
    always_comb begin
        if (mem_state && !mem_ready_i && !timeout) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = '0;
        end
        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    // State and status registers; reset aborts any access in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Control strobes decoded from state; forced low while reset is held.
    always_comb begin
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        iord_o      = 1'b0;
        acc_write_o = 1'b0;
        acc_src_o   = 2'd0;
        alu_op_o    = 3'd0;
        halted_o    = 1'b0;
        if (!reset_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                    end
                end
                S_EXEC_ALU: begin
                    acc_write_o = 1'b1;
                    if (opcode_i == OP_LOADI) begin
                        acc_src_o = 2'd2;
                    end else begin
                        alu_op_o = 3'(opcode_i - 5'd1);
                    end
                end
                S_MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                    if (mem_ready_i) begin
                        acc_write_o = 1'b1;
                        acc_src_o   = 2'd1;
                    end
                end
                S_MEM_WR: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                end
                S_BRANCH: begin
                    pc_src_o   = 1'b1;
                    pc_write_o = (opcode_i == OP_JUMP) ? 1'b1 : acc_zero_i;
                end
                S_HALT:  halted_o = 1'b1;
                default: halted_o = 1'b0;
            endcase
        end
    end

    assign illegal_op_o = illegal_q;
    assign bus_error_o  = bus_err_q;
    assign retired_o    = retired_q;

endmodule

// File: doc/acc_control_fsm.md
Name: acc_control_fsm

Overview:
- Multi-cycle control sequencer for the accumulator processor.
- Drives the instruction register load, PC update, memory request and accumulator/ALU controls through fetch, decode and execute.
- Consumes the 5-bit opcode field held in the instruction register and the accumulator zero flag.
- Handshakes with a variable-latency memory and counts retired instructions.

Parameters:
- WAIT_LIMIT, 255: maximum cycles spent waiting for mem_ready in any memory state before bus error.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  5  IR opcode field (IR bits 4:0), valid from DECODE onward.
- acc_zero  input  1  accumulator == 0.
- mem_ready  input  1  memory completes the current read/write this cycle.
- ir_write  output  1  load instruction register.
- pc_write  output  1  load PC.
- pc_src  output  1  0 = PC+1, 1 = IR operand (branch/jump target).
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request (data = accumulator).
- iord  output  1  0 = address from PC, 1 = address from IR operand.
- acc_write  output  1  load accumulator.
- acc_src  output  2  0 = ALU, 1 = memory data, 2 = IR immediate.
- alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR.
- halted  output  1  core in HALT.
- illegal_op  output  1  sticky: undefined opcode decoded.
- bus_error  output  1  sticky: memory wait exceeded WAIT_LIMIT.
- retired  output  CNT_W  instructions completed, wraps modulo 2^CNT_W.

Behaviour:
- States: FETCH, DECODE, EXEC_ALU, MEM_RD, MEM_WR, BRANCH, HALT.
- Reset (async):
  - state=FETCH; wait counter=0; retired=0; illegal_op=0; bus_error=0.
  - While reset is high, all control outputs are 0.
  - Reset mid-operation aborts any outstanding memory request immediately; nothing completes.
- Control outputs are combinational from state, plus mem_ready where noted.
  - Unlisted outputs are 0.
  - alu_op and acc_src hold 0 outside their states.
- FETCH:
  - mem_read=1, iord=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
  - Otherwise stay.
- DECODE: one cycle, no side effects. Opcode dispatch:
  - 0x00 NOP: -> FETCH.
  - 0x01-0x04 ADD/SUB/AND/OR: -> EXEC_ALU.
  - 0x05 LOAD: -> MEM_RD.
  - 0x06 STORE: -> MEM_WR.
  - 0x07 LOADI: -> EXEC_ALU with acc_src=2.
  - 0x08 BEQZ, 0x09 JUMP: -> BRANCH.
  - 0x1F HALT: -> HALT.
  - Any other opcode: set illegal_op, treat as NOP.
- EXEC_ALU:
  - acc_write=1.
  - ADD/SUB/AND/OR: acc_src=0, alu_op=opcode-1.
  - LOADI: acc_src=2.
  - Next state FETCH.
- MEM_RD:
  - mem_read=1, iord=1.
  - On mem_ready: acc_write=1, acc_src=1; next state FETCH.
- MEM_WR:
  - mem_write=1, iord=1.
  - On mem_ready: next state FETCH.
- BRANCH:
  - JUMP: pc_write=1, pc_src=1.
  - BEQZ: pc_write=acc_zero, pc_src=1.
  - Next state FETCH.
- HALT: halted=1; all other controls 0; exit only via reset.
- Wait counter:
  - Increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on mem_ready or on any state change.
  - If the counter reaches WAIT_LIMIT with mem_ready still 0: set bus_error, next state HALT, no completion.
  - If mem_ready and the limit coincide, mem_ready wins.
- Retired counter:
  - Increments by 1 on the cycle an instruction leaves its last state toward FETCH or HALT.
  - Counted: NOP, illegal opcode, EXEC_ALU, memory completion, BRANCH, DECODE of HALT.
  - Not incremented on bus-error entry to HALT.
  - Wraps from all-ones to 0.
- mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
- Instruction latency with mem_ready=1 on first request cycle:
  - ALU/LOADI/branch: 3 cycles.
  - LOAD/STORE: 3 cycles.
  - Each extra memory wait cycle adds 1.

Test Plan:
- Reset, then ADD (0x01) with mem_ready tied 1 -> ir_write+pc_write in cycle 0; DECODE in cycle 1; acc_write=1, alu_op=0, acc_src=0 in cycle 2; retired=1.
- LOAD (0x05), mem_ready held low 3 cycles in MEM_RD -> mem_read=1, iord=1 held 4 cycles; acc_write and acc_src=1 only in the mem_ready cycle; retired increments once.
- BEQZ (0x08) with acc_zero=0, then again with acc_zero=1 -> pc_write=0 first time, then pc_write=1 with pc_src=1; both retire.
- Opcode 0x0C -> illegal_op=1 sticky; no acc/pc/mem writes beyond fetch; next FETCH follows; retired increments.
- WAIT_LIMIT=4, FETCH with mem_ready=0 -> after 4 wait cycles bus_error=1, halted=1, all controls 0; stays halted until reset; reset clears all flags.
- Assert reset during MEM_WR with mem_write=1 -> mem_write drops immediately (asynchronous); after release, FETCH with retired=0.
